hex_display_scanner: RTL

//   Time-multiplexed controller for NDIG active-low 7-segment digits sharing one

---
 rtl/hex_display_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 13 +
 rtl/hex_display_scanner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner.
//   SEG_BLANK    - active-low segment pattern with every segment off
//   SEG_TABLE    - active-low 7-segment patterns for 0..F, bit6=g .. bit0=a
//   NDIG_DEFAULT - default number of multiplexed digits
package hex_display_pkg;

    localparam int unsigned NDIG_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed so that SEG_TABLE[n] is the pattern for hex digit n; the list
    // below therefore runs from F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex to active-low 7-segment decoder.
//   hex   in  4  value 0..F
//   seg_n out 7  active-low segments, bit6=g .. bit0=a
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for NDIG active-low 7-segment digits on one shared
// segment bus. Each digit holds a 4-bit hex value loaded through a write port;
// a prescaler steps the scan index and one shared decoder feeds the pins.
//   CLOCK_50   in   1            system clock, rising edge
//   reset      in   1            synchronous active-high reset
//   wr_en      in   1            write strobe
//   wr_addr    in   clog2(NDIG)  digit index to write (>= NDIG ignored)
//   wr_data    in   4            hex value
//   blank      in   NDIG         per-digit forced blank
//   dig_n      out  NDIG         active-low digit enables, one-hot-low
//   seg_n      out  7            active-low segments, bit6=g .. bit0=a
//   frame_done out  1            one-cycle pulse after the last digit slot
// NDIG must be >= 2 and DIV >= 2.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int unsigned NDIG        = NDIG_DEFAULT,
    parameter int unsigned DIV         = 50000,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(NDIG)-1:0] wr_addr,
    input  logic [3:0]              wr_data,
    input  logic [NDIG-1:0]         blank,
    output logic [NDIG-1:0]         dig_n,
    output logic [6:0]              seg_n,
    output logic                    frame_done
);

    localparam int unsigned IW = $clog2(NDIG);
    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      digits_q [NDIG];
    logic [NDIG-1:0] dig_n_q, dig_n_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic            frame_done_q, frame_done_d;

    logic            tick;
    logic            last;
    logic [NDIG-1:0] lz_mask;
    logic            zero_above;
    logic [NDIG-1:0] dig_sel;
    logic [6:0]      dec_seg_n;
    logic            blanked;

    assign tick = (cnt_q == CW'(DIV - 1));
    assign last = (idx_q == IW'(NDIG - 1));

    // A digit is a leading zero when it and every more significant digit are
    // zero. Digit 0 is excluded so a value of zero still shows one "0".
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            zero_above = zero_above & (digits_q[i] == 4'h0);
            lz_mask[i] = zero_above && (i > 0) && (LZ_SUPPRESS != 0);
        end
    end

    hex_to_seg7 u_dec (
        .hex   (digits_q[idx_q]),
        .seg_n (dec_seg_n)
    );

    assign blanked = blank[idx_q] | lz_mask[idx_q];

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = last ? '0 : idx_q + IW'(1);
        end

        dig_sel        = '0;
        dig_sel[idx_q] = 1'b1;
        dig_n_d        = ~dig_sel;
        seg_n_d        = blanked ? SEG_BLANK : dec_seg_n;
        // Dark for the tick cycle so the segment bus settles between digits.
        if (tick) begin
            dig_n_d = '1;
            seg_n_d = SEG_BLANK;
        end
        frame_done_d = tick & last;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            dig_n_q      <= '1;
            seg_n_q      <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dig_n_q      <= dig_n_d;
            seg_n_q      <= seg_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Writes are independent of the scan, so a write and a tick in the same
    // cycle both take effect.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                digits_q[i] <= 4'h0;
            end
        end else if (wr_en && (32'(wr_addr) < NDIG)) begin
            digits_q[wr_addr] <= wr_data;
        end
    end

    assign dig_n      = dig_n_q;
    assign seg_n      = seg_n_q;
    assign frame_done = frame_done_q;

endmodule
